// File: rtl/code_frame_receiver.sv
// Serial frame receiver: hunts for a sync word (with bit-error tolerance), then
// deserialises WORDS_PER_FRAME data words MSB-first into a one-entry output buffer.
module code_frame_receiver #(
  parameter int unsigned              DATA_W          = 8,
  parameter int unsigned              SYNC_W          = 8,
  parameter logic [SYNC_W-1:0]        SYNC_WORD       = 8'b10010101,
  parameter int unsigned              WORDS_PER_FRAME = 4,
  parameter int unsigned              SYNC_TOL        = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_input,
  input  logic              io_in_valid,
  output logic [DATA_W-1:0] io_out_data,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic              io_out_first,
  output logic              io_out_last,
  output logic              io_overflow,
  output logic              io_locked
);

  localparam int unsigned CNT_W  = $clog2(SYNC_W + 1);
  localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned WORD_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;

  typedef enum logic {
    S_HUNT = 1'b0,
    S_DATA = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SYNC_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]    fill_q, fill_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_first_q, out_first_d;
  logic                out_last_q, out_last_d;
  logic                overflow_q, overflow_d;
  logic                locked_q, locked_d;

  logic [SYNC_W-1:0]   win_shift;
  logic [DATA_W-1:0]   data_shift;
  logic [CNT_W-1:0]    fill_inc;
  logic                sync_hit;
  logic                word_done;
  logic                frame_done;

  function automatic logic [CNT_W-1:0] popcount(input logic [SYNC_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(SYNC_W); i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Window/shift-register candidates include the bit strobed this cycle
  assign win_shift  = SYNC_W'({win_q, io_input});
  assign data_shift = DATA_W'({shreg_q, io_input});
  assign fill_inc   = (fill_q == CNT_W'(SYNC_W)) ? fill_q : fill_q + CNT_W'(1);
  assign sync_hit   = (fill_inc == CNT_W'(SYNC_W)) &&
                      (popcount(win_shift ^ SYNC_WORD) <= CNT_W'(SYNC_TOL));
  assign word_done  = (bit_cnt_q == BIT_W'(DATA_W - 1));
  assign frame_done = word_done && (word_cnt_q == WORD_W'(WORDS_PER_FRAME - 1));

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_HUNT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (io_in_valid) begin
      case (state_q)
        S_HUNT:  if (sync_hit)   state_d = S_DATA;
        S_DATA:  if (frame_done) state_d = S_HUNT;
        default: state_d = S_HUNT;
      endcase
    end
  end

  always_comb begin
    win_d       = win_q;
    fill_d      = fill_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    overflow_d  = 1'b0;
    locked_d    = (state_d == S_DATA);

    if (out_valid_q && io_out_ready) out_valid_d = 1'b0;

    if (io_in_valid) begin
      case (state_q)
        S_HUNT: begin
          if (sync_hit) begin
            win_d      = '0;
            fill_d     = '0;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
          end else begin
            win_d  = win_shift;
            fill_d = fill_inc;
          end
        end
        S_DATA: begin
          shreg_d = data_shift;
          if (word_done) begin
            bit_cnt_d = '0;
            // Buffer accepts when empty or being drained this same cycle
            if (!out_valid_q || io_out_ready) begin
              out_data_d  = data_shift;
              out_valid_d = 1'b1;
              out_first_d = (word_cnt_q == '0);
              out_last_d  = (word_cnt_q == WORD_W'(WORDS_PER_FRAME - 1));
            end else begin
              overflow_d = 1'b1;
            end
            if (frame_done) begin
              word_cnt_d = '0;
              win_d      = '0;
              fill_d     = '0;
            end else begin
              word_cnt_d = word_cnt_q + WORD_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      win_q       <= '0;
      fill_q      <= '0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      win_q       <= win_d;
      fill_q      <= fill_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
      locked_q    <= locked_d;
    end
  end

  assign io_out_data  = out_data_q;
  assign io_out_valid = out_valid_q;
  assign io_out_first = out_first_q;
  assign io_out_last  = out_last_q;
  assign io_overflow  = overflow_q;
  assign io_locked    = locked_q;

endmodule

// File: tb/tb_code_frame_receiver.sv
// Directed bench for code_frame_receiver: two instances (sync tolerance 0 and 1)
// share one bit stream; expected words and flags are hand-computed.
module tb_code_frame_receiver;

  logic       clock = 1'b0;
  logic       reset;
  logic       io_input;
  logic       io_in_valid;
  logic       io_out_ready;

  logic [7:0] d0_data, d1_data;
  logic       d0_valid, d0_first, d0_last, d0_ovf, d0_locked;
  logic       d1_valid, d1_first, d1_last, d1_ovf, d1_locked;

  int checks = 0;
  int errors = 0;
  int vcnt0  = 0;
  int vcnt1  = 0;
  int ovcnt0 = 0;

  always #5 clock = ~clock;

  code_frame_receiver #(
    .DATA_W(8), .SYNC_W(8), .SYNC_WORD(8'h95), .WORDS_PER_FRAME(2), .SYNC_TOL(0)
  ) u_dut0 (
    .clock(clock), .reset(reset), .io_input(io_input), .io_in_valid(io_in_valid),
    .io_out_data(d0_data), .io_out_valid(d0_valid), .io_out_ready(io_out_ready),
    .io_out_first(d0_first), .io_out_last(d0_last), .io_overflow(d0_ovf),
    .io_locked(d0_locked)
  );

  code_frame_receiver #(
    .DATA_W(8), .SYNC_W(8), .SYNC_WORD(8'h95), .WORDS_PER_FRAME(2), .SYNC_TOL(1)
  ) u_dut1 (
    .clock(clock), .reset(reset), .io_input(io_input), .io_in_valid(io_in_valid),
    .io_out_data(d1_data), .io_out_valid(d1_valid), .io_out_ready(io_out_ready),
    .io_out_first(d1_first), .io_out_last(d1_last), .io_overflow(d1_ovf),
    .io_locked(d1_locked)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive a bit (strobed or idle), sample #1 after the edge
  task automatic step(input logic b, input logic vld);
    io_input    = b;
    io_in_valid = vld;
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
    if (d0_valid) vcnt0++;
    if (d1_valid) vcnt1++;
    if (d0_ovf)   ovcnt0++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    vcnt0 = 0;
    vcnt1 = 0;
    ovcnt0 = 0;
  endtask

  // Sends nbits MSB-first; checks lock at bit 8 and first word at bit 16 on dut0
  task automatic run_frame(input logic [31:0] stream, input int nbits, input bit gaps,
                           input logic [7:0] w0, input bit chk);
    for (int i = 1; i <= nbits; i++) begin
      if (gaps) while ($urandom_range(0, 1) == 1) step(1'b0, 1'b0);
      step(stream[nbits - i], 1'b1);
      if (chk && i == 7)  check("locked_before_sync", 32'(d0_locked), 32'd0);
      if (chk && i == 8)  check("locked_after_sync", 32'(d0_locked), 32'd1);
      if (chk && i == 16) begin
        check("w0_valid", 32'(d0_valid), 32'd1);
        check("w0_data",  32'(d0_data),  32'(w0));
        check("w0_first", 32'(d0_first), 32'd1);
        check("w0_last",  32'(d0_last),  32'd0);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    io_input     = 1'b0;
    io_in_valid  = 1'b0;
    io_out_ready = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("rst_valid",  32'(d0_valid),  32'd0);
    check("rst_data",   32'(d0_data),   32'd0);
    check("rst_first",  32'(d0_first),  32'd0);
    check("rst_last",   32'(d0_last),   32'd0);
    check("rst_ovf",    32'(d0_ovf),    32'd0);
    check("rst_locked", 32'(d0_locked), 32'd0);
    do_reset();

    // Basic frame, ready high, bit per clock
    run_frame(32'h0095A755, 24, 1'b0, 8'hA7, 1'b1);
    check("s1_w1_valid", 32'(d0_valid),  32'd1);
    check("s1_w1_data",  32'(d0_data),   32'h55);
    check("s1_w1_first", 32'(d0_first),  32'd0);
    check("s1_w1_last",  32'(d0_last),   32'd1);
    check("s1_unlock",   32'(d0_locked), 32'd0);
    step(1'b0, 1'b0);
    check("s1_drained",  32'(d0_valid),  32'd0);
    check("s1_words",    32'(vcnt0),     32'd2);
    do_reset();

    // One-bit sync error: rejected at tolerance 0, accepted at tolerance 1
    run_frame(32'h0097A755, 24, 1'b0, 8'h00, 1'b0);
    check("tol1_w1_data", 32'(d1_data),   32'h55);
    check("tol1_w1_last", 32'(d1_last),   32'd1);
    check("tol1_unlock",  32'(d1_locked), 32'd0);
    check("tol1_words",   32'(vcnt1),     32'd2);
    check("tol0_words",   32'(vcnt0),     32'd0);
    check("tol0_locked",  32'(d0_locked), 32'd0);
    do_reset();

    // Backpressure: second word dropped, first word retained
    io_out_ready = 1'b0;
    run_frame(32'h0095A755, 24, 1'b0, 8'hA7, 1'b1);
    check("bp_ovf_pulse", 32'(d0_ovf),   32'd1);
    check("bp_hold_data", 32'(d0_data),  32'hA7);
    check("bp_hold_first",32'(d0_first), 32'd1);
    check("bp_hold_valid",32'(d0_valid), 32'd1);
    step(1'b0, 1'b0);
    check("bp_ovf_once",  32'(d0_ovf),   32'd0);
    io_out_ready = 1'b1;
    step(1'b0, 1'b0);
    io_out_ready = 1'b0;
    check("bp_drained",   32'(d0_valid), 32'd0);
    check("bp_ovf_count", 32'(ovcnt0),   32'd1);
    io_out_ready = 1'b1;
    do_reset();

    // Random strobe gaps
    run_frame(32'h0095A755, 24, 1'b1, 8'hA7, 1'b1);
    check("gap_w1_data", 32'(d0_data),  32'h55);
    check("gap_w1_last", 32'(d0_last),  32'd1);
    check("gap_w1_valid",32'(d0_valid), 32'd1);
    step(1'b0, 1'b0);
    check("gap_words",   32'(vcnt0),    32'd2);
    do_reset();

    // Reset after sync plus four data bits, then a clean frame
    run_frame(32'h0000095A, 12, 1'b0, 8'h00, 1'b0);
    check("mr_locked_pre", 32'(d0_locked), 32'd1);
    check("mr_no_out_pre", 32'(vcnt0),     32'd0);
    do_reset();
    check("mr_locked_rst", 32'(d0_locked), 32'd0);
    check("mr_valid_rst",  32'(d0_valid),  32'd0);
    run_frame(32'h00950FF0, 24, 1'b0, 8'h0F, 1'b1);
    check("mr_w1_data", 32'(d0_data), 32'hF0);
    check("mr_w1_last", 32'(d0_last), 32'd1);
    check("mr_words",   32'(vcnt0),   32'd2);
    do_reset();

    // Sync pattern inside data must not cause a relock
    run_frame(32'h95959500, 32, 1'b0, 8'h95, 1'b1);
    check("emb_w1_data",  32'(d0_data),   32'h95);
    check("emb_w1_last",  32'(d0_last),   32'd1);
    check("emb_locked",   32'(d0_locked), 32'd0);
    check("emb_words",    32'(vcnt0),     32'd2);
    step(1'b0, 1'b0);
    check("emb_locked_end", 32'(d0_locked), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/code_frame_receiver.md
# code_frame_receiver

Parametrised serial frame receiver for the FSK-Hamming receive path. It sits after the demodulator and takes one recovered bit per strobe. It hunts for a programmable sync word, allowing a configurable number of bit errors, then deserialises a fixed number of data words MSB-first. Each word is presented on a valid/ready output buffer, with first/last frame markers and overflow reporting.

## Interface
- DATA_W, default 8: data word width in bits.
- SYNC_W, default 8: sync word width in bits.
- SYNC_WORD, default 8'b10010101: sync pattern, MSB received first.
- WORDS_PER_FRAME, default 4: data words per frame, ≥1.
- SYNC_TOL, default 0: maximum number of mismatching bits still accepted as sync.

- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- io_input  in  1  received bit; sampled only when io_in_valid=1.
- io_in_valid  in  1  bit strobe.
- io_out_data  out  DATA_W  buffered data word.
- io_out_valid  out  1  io_out_data holds an unread word.
- io_out_ready  in  1  consumer accepts the word when io_out_valid & io_out_ready.
- io_out_first  out  1  the buffered word is word 0 of its frame.
- io_out_last  out  1  the buffered word is word WORDS_PER_FRAME-1.
- io_overflow  out  1  one-cycle pulse: a completed word was dropped.
- io_locked  out  1  high while in the DATA state.

## Operation
- States:
  - HUNT: sync search.
  - DATA: word collection.
- HUNT:
  - Each strobed bit shifts into a SYNC_W window at the LSB; a fill counter saturates at SYNC_W.
  - Match condition: fill==SYNC_W and popcount(window^SYNC_WORD) ≤ SYNC_TOL. The comparison includes the bit strobed this cycle.
  - On match: go to DATA; clear the bit counter, word counter, window and fill counter.
- DATA:
  - Each strobed bit shifts into the data shift register at the LSB.
  - When the DATA_W-th bit arrives, the word completes:
    - The word is written to the output buffer with first=(word count==0) and last=(word count==WORDS_PER_FRAME-1).
    - The bit counter clears and the word counter increments.
  - After the last word, return to HUNT with the window and fill counter cleared. Sync bits are never taken from data bits.
- Output buffer (one entry):
  - The word is written if the buffer is empty, or if it is full and being read in the same cycle. A read and a write in the same cycle is legal and causes no overflow.
  - Otherwise the new word is dropped, io_overflow pulses, and the buffered word and its flags are unchanged.
  - Frame sequencing continues regardless of overflow.
- io_in_valid=0: all state holds.

## Timing
- Reset values:
  - io_out_data=0, io_out_valid=0, io_out_first=0, io_out_last=0, io_overflow=0, io_locked=0.
  - State HUNT; window, fill counter, bit counter and word counter all 0.
- Reset mid-frame: the buffered word is discarded and hunting restarts. There is no partial-word output.
- Lock latency: io_locked rises the cycle after the strobe carrying the final sync bit.
- Word latency: io_out_valid and data rise the cycle after the strobe carrying the word's final bit.
- io_out_valid stays high until a cycle with io_out_ready=1; it falls the next cycle unless a new word is written in the same cycle.
- io_overflow is asserted for exactly the cycle after the dropped word's final strobe.
- io_locked falls the cycle after the final bit of the last word.
- Sustained throughput: one bit per clock with io_in_valid tied high and io_out_ready=1. There are no bubbles between words or between frames.
- Combinational paths: none from inputs to outputs.

## Test plan
- Parameters: DATA_W=8, SYNC_W=8, SYNC_WORD=8'h95, WORDS_PER_FRAME=2, SYNC_TOL=0, ready=1, bit per clock.
  - Stimulus: bits 10010101 10100111 01010101.
  - Required: io_out_data=0xA7 with first=1 one cycle after bit 16, then 0x55 with last=1 one cycle after bit 24. io_locked spans cycles 9..24.
- Sync tolerance:
  - Stimulus: sync 10010111 (one bit error), then data as above.
  - SYNC_TOL=0: no output.
  - SYNC_TOL=1: locks and delivers 0xA7 and 0x55.
- Backpressure:
  - Stimulus: io_out_ready=0 throughout the frame.
  - Required: 0xA7 held with first=1. io_overflow pulses once after bit 24, and the buffer still holds 0xA7. After ready is raised for one cycle, io_out_valid falls.
- Gaps:
  - Stimulus: the scenario-1 stream with io_in_valid randomly low (about 50%).
  - Required: identical words and flags; each word appears one cycle after its final strobe.
- Reset mid-frame:
  - Stimulus: reset asserted for one cycle after sync plus 4 data bits, then a full frame 10010101 00001111 11110000.
  - Required: no output from the aborted frame; then 0x0F (first) and 0xF0 (last).
- Data-embedded sync:
  - Stimulus: frame data words 0x95, 0x95, followed by 00000000.
  - Required: two words of 0x95 are output; no relock occurs after the frame; io_locked stays 0.
